// File: rtl/acc_shift_alu_pkg.sv
// Shared types for the accumulator shift ALU: opcode and sequencer-state enums
// plus a small opcode classifier used by the top level.
package definitions;

    typedef enum logic [3:0] {
        kADD = 4'd0,
        kSUB = 4'd1,
        kAND = 4'd2,
        kXOR = 4'd3,
        kLDI = 4'd4,
        kSHL = 4'd5,
        kSHR = 4'd6,
        kASR = 4'd7,
        kROL = 4'd8,
        kNOT = 4'd9,
        kCLR = 4'd10
    } alu_op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } alu_state_t;

    // Opcodes from here up to 4'hF are treated as NOP.
    localparam logic [3:0] OP_FIRST_NOP = 4'd11;

    function automatic logic is_shift_op(input alu_op_t op);
        case (op)
            kSHL, kSHR, kASR, kROL: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/acc_shift_alu_if.sv
// Request/result bundle between the controller (master) and the ALU (slave).
interface acc_shift_alu_if #(
    parameter int W = 8
);
    import definitions::*;

    logic         start;
    alu_op_t      op;
    logic [W-1:0] in_a;
    logic         ci;
    logic [W-1:0] acc;
    logic         co;
    logic         z;
    logic         neg;
    logic         ov;
    logic         busy;
    logic         done;

    modport master (
        output start, op, in_a, ci,
        input  acc, co, z, neg, ov, busy, done
    );

    modport slave (
        input  start, op, in_a, ci,
        output acc, co, z, neg, ov, busy, done
    );
endinterface

// File: rtl/acc_shift_alu_shift_step.sv
// One-bit shift/rotate step; result packs the bit leaving the word above the new value.
module alu_shift_step
    import definitions::*;
#(
    parameter int W = 8
) (
    input  alu_op_t      op,
    input  logic [W-1:0] value,
    output logic [W:0]   result
);

    // Single-position move of the word in the direction selected by op.
    always_comb begin
        case (op)
            kSHL:    result = {value[W-1], value[W-2:0], 1'b0};
            kSHR:    result = {value[0], 1'b0, value[W-1:1]};
            kASR:    result = {value[0], value[W-1], value[W-1:1]};
            kROL:    result = {value[W-1], value[W-2:0], value[W-1]};
            default: result = {1'b0, value};
        endcase
    end

endmodule

// File: rtl/acc_shift_alu.sv
// Registered accumulator ALU with flags and an iterative one-bit-per-cycle shifter.
module acc_shift_alu
    import definitions::*;
#(
    parameter int W  = 8,
    parameter int CW = $clog2(W) + 1
) (
    input logic            CLK,
    input logic            reset,
    acc_shift_alu_if.slave bus
);

    localparam logic [W-1:0]  W_VAL    = W'(W);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(W);

    alu_state_t    state_r, state_s;
    alu_op_t       op_r, op_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [W-1:0]  acc_r, acc_s;
    logic          co_r, co_s, z_r, z_s, neg_r, neg_s, ov_r, ov_s;
    logic          done_r, done_s, busy_r;

    logic [W-1:0]  addend_s, logic_res_s;
    logic          cin_s, add_ov_s;
    logic [W:0]    sum_s, step_s;
    logic [CW-1:0] amount_s;

    alu_shift_step #(.W(W)) u_step (
        .op     (op_r),
        .value  (acc_r),
        .result (step_s)
    );

    // Shared adder: SUB feeds the inverted operand with a forced carry-in.
    always_comb begin
        if (bus.op == kSUB) begin
            addend_s = ~bus.in_a;
            cin_s    = 1'b1;
        end else begin
            addend_s = bus.in_a;
            cin_s    = bus.ci;
        end
        sum_s    = {1'b0, acc_r} + {1'b0, addend_s} + {{W{1'b0}}, cin_s};
        add_ov_s = (acc_r[W-1] == addend_s[W-1]) && (sum_s[W-1] != acc_r[W-1]);
    end

    // Results of the single-cycle ops that only affect z/neg.
    always_comb begin
        case (bus.op)
            kAND:    logic_res_s = acc_r & bus.in_a;
            kXOR:    logic_res_s = acc_r ^ bus.in_a;
            kNOT:    logic_res_s = ~acc_r;
            default: logic_res_s = bus.in_a;
        endcase
    end

    // Shift count: rotates wrap modulo W, shifts saturate at W using the full-width amount.
    always_comb begin
        if (bus.op == kROL) begin
            amount_s = CW'(bus.in_a % W_VAL);
        end else if (bus.in_a >= W_VAL) begin
            amount_s = CNT_FULL;
        end else begin
            amount_s = CW'(bus.in_a);
        end
    end

    // Next-state and datapath selection for the IDLE/SHIFT sequencer.
    always_comb begin
        state_s = state_r;
        op_s    = op_r;
        cnt_s   = cnt_r;
        acc_s   = acc_r;
        co_s    = co_r;
        z_s     = z_r;
        neg_s   = neg_r;
        ov_s    = ov_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    done_s = 1'b1;
                    case (bus.op)
                        kADD, kSUB: begin
                            acc_s = sum_s[W-1:0];
                            co_s  = sum_s[W];
                            ov_s  = add_ov_s;
                            z_s   = ~|sum_s[W-1:0];
                            neg_s = sum_s[W-1];
                        end
                        kAND, kXOR, kLDI, kNOT: begin
                            acc_s = logic_res_s;
                            z_s   = ~|logic_res_s;
                            neg_s = logic_res_s[W-1];
                        end
                        kSHL, kSHR, kASR, kROL: begin
                            // A zero-length shift completes now; only z/neg are refreshed.
                            if (amount_s == CNT_ZERO) begin
                                z_s   = ~|acc_r;
                                neg_s = acc_r[W-1];
                            end else begin
                                state_s = SHIFT;
                                op_s    = bus.op;
                                cnt_s   = amount_s;
                                done_s  = 1'b0;
                            end
                        end
                        kCLR: begin
                            acc_s = {W{1'b0}};
                            co_s  = 1'b0;
                            z_s   = 1'b0;
                            neg_s = 1'b0;
                            ov_s  = 1'b0;
                        end
                        default: begin
                            acc_s = acc_r;
                        end
                    endcase
                end else begin
                    done_s = 1'b0;
                end
            end
            SHIFT: begin
                acc_s = step_s[W-1:0];
                co_s  = step_s[W];
                cnt_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_s = IDLE;
                    z_s     = ~|step_s[W-1:0];
                    neg_s   = step_s[W-1];
                    done_s  = 1'b1;
                end else begin
                    state_s = SHIFT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Architectural state; reset wins over any shift in flight and suppresses its done.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r <= IDLE;
            op_r    <= kADD;
            cnt_r   <= CNT_ZERO;
            acc_r   <= {W{1'b0}};
            co_r    <= 1'b0;
            z_r     <= 1'b0;
            neg_r   <= 1'b0;
            ov_r    <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            op_r    <= op_s;
            cnt_r   <= cnt_s;
            acc_r   <= acc_s;
            co_r    <= co_s;
            z_r     <= z_s;
            neg_r   <= neg_s;
            ov_r    <= ov_s;
            done_r  <= done_s;
            busy_r  <= (state_s == SHIFT);
        end
    end

    assign bus.acc  = acc_r;
    assign bus.co   = co_r;
    assign bus.z    = z_r;
    assign bus.neg  = neg_r;
    assign bus.ov   = ov_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: doc/acc_shift_alu.md
# acc_shift_alu

Parametrised, registered accumulator ALU: the successor to the combinational 8-bit demo ALU. It owns the accumulator and a four-bit flag register (C, Z, N, V) internally, is generalised to `W` bits, and adds arithmetic right shift and rotate. Shifts and rotates run as a one-bit-per-cycle iterative sequencer behind a start/busy/done handshake, so no barrel shifter is needed. It sits between the decoder/controller and the register file and data-memory paths.

## Interface
- `W`, default 8: datapath width, at least 4.
- `CW`, default `$clog2(W)+1`: width of the shift counter.
- `CLK` in, 1 bit: the single clock; every register updates on the rising edge.
- `reset` in, 1 bit: synchronous, active-high. Sampled only on the rising edge of `CLK`.
- `start` in, 1 bit: request. Accepted only when `busy` is 0.
- `op` in, 4 bits: opcode, type `alu_op_t`.
- `in_a` in, `W` bits: operand, immediate, or shift amount.
- `ci` in, 1 bit: carry-in, used by ADD only.
- `acc` out, `W` bits: accumulator register.
- `co`, `z`, `neg`, `ov` out, 1 bit each: flag registers.
- `busy` out, 1 bit: high while the sequencer is in `SHIFT`.
- `done` out, 1 bit: one-cycle pulse when a result has been committed.

## Operation
- **Opcodes** (package encoding):
  - ADD 0: `{c,acc} = acc + in_a + ci`.
  - SUB 1: `acc + ~in_a + 1`. `co` = 1 means no borrow, i.e. `acc >= in_a` unsigned.
  - AND 2, XOR 3: bitwise with `in_a`.
  - LDI 4: `acc = in_a`.
  - SHL 5: logical left shift.
  - SHR 6: logical right shift.
  - ASR 7: arithmetic right shift; the MSB is replicated.
  - ROL 8: rotate left.
  - NOT 9: bitwise `~acc`.
  - CLR 10: `acc` and all flags are cleared.
  - 11–15: NOP.
- **Flag update rules:**
  - `z` and `neg` are recomputed from the new `acc` on every op that writes `acc`: ADD, SUB, AND, XOR, LDI, all shifts, NOT.
  - `co` is written by ADD, SUB and the shifts. For a shift it holds the last bit shifted out; for ROL it holds the bit that wrapped. A zero-length shift leaves `co` unchanged.
  - `ov` is written by ADD and SUB only, using the signed overflow rule: operand signs are equal and the result sign differs. For SUB the operand taken is the inverted `in_a`.
  - Flags not listed for an op hold their value.
- **Sequencer states:**
  - `IDLE` → on `start` with a single-cycle op (including NOP): commit result and flags at this edge, `done`=1 next cycle, stay in `IDLE`.
  - `IDLE` → on `start` with a shift/rotate op: `cnt = min(in_a, W)`. For ROL, `cnt = in_a mod W`.
    - If `cnt == 0`: commit immediately as a single-cycle op; `acc` is unchanged but `z`/`neg` are recomputed.
    - Otherwise go to `SHIFT` and latch the op.
  - In `SHIFT`, each edge shifts `acc` by one bit, updates `co`, and decrements `cnt`. On the edge where `cnt` goes 1→0: update `z`/`neg`, return to `IDLE`, `done`=1 next cycle.
- **Shift amount width:** `in_a` is compared at full width. A shift amount of `W` or more (logical/arithmetic) gives all zeros, or all sign bits for ASR.
- `start` while `busy` is ignored: no queueing, no error flag.
- `acc` and flags are not written while in `SHIFT` except by the sequencer itself.

## Timing
- **Reset values:** `acc`=0, `co`=`z`=`neg`=`ov`=0, `busy`=0, `done`=0, state `IDLE`, `cnt`=0.
- **Reset priority:** reset overrides everything, including a mid-shift operation. The partial result is discarded and no `done` is produced.
- **Single-cycle op:** `start` is sampled at edge k. `acc`/flags are valid after edge k; `done` is high for the cycle between k and k+1.
- **Shift by n (1 ≤ n ≤ W):**
  - Accepted at edge k.
  - `busy` is high from after edge k until after edge k+n.
  - Final shift happens at edge k+n; `done` is high for the cycle after edge k+n.
  - Total latency is n+1 edges.
- **Back-to-back:** a new `start` is accepted in the same cycle `done` is high, since `busy` is already 0.
- **Outputs:** all outputs come directly from registers; there is no combinational path from inputs to outputs.

## Structure
- Package `definitions`:
  - `alu_op_t`, a 4-bit enum (kADD…kCLR), kept compatible with the existing `op_mne` names.
  - `alu_state_t` with values `IDLE` and `SHIFT`.
  - Opcode constants.
- One natural sub-module, `alu_shift_step`: a combinational one-bit shift/rotate/ASR step returning `{bit_out, next_acc}`, parametrised by `W`.
- The top level contains the sequencer, the single-cycle datapath and the flag logic.

## Test plan
- **ADD with carry-out:** reset; LDI 0xFF; ADD `in_a`=0x01, `ci`=0 → `acc`=0x00, `co`=1, `z`=1, `neg`=0, `ov`=0, `done` one cycle after start.
- **Signed overflow and borrow:**
  - LDI 0x7F; ADD 0x01 → `acc`=0x80, `ov`=1, `neg`=1, `co`=0.
  - LDI 0x05; SUB 0x07 → `acc`=0xFE, `co`=0, `neg`=1, `ov`=0.
- **SHL 3 on 0x81:** `busy` is high 3 cycles → `acc`=0x08, `co`=0. `done` is 4 edges after start. A `start` issued mid-shift is ignored and `acc` is unaffected.
- **Right shifts:**
  - LDI 0x80; ASR 2 → 0xE0, `co`=0, `neg`=1.
  - LDI 0x81; SHR 9 → capped at 8 → 0x00, `z`=1, `co`=1.
  - ROL 9 → same as ROL 1.
- **Reset mid-shift:** SHL 5, assert `reset` on the 2nd shift cycle → next cycle `acc`=0, all flags 0, `busy`=0, and no `done` pulse.
- **NOT, CLR and zero-length shift:**
  - LDI 0x0F; NOT → 0xF0, `neg`=1.
  - CLR → all zero.
  - SHL 0 → `done` next cycle, `co` unchanged.
